// File: rtl/dram_arbiter.sv
// Two-requester DRAM arbiter: round-robin grant onto a single-outstanding
// AXI master (requester 0 line reads, requester 1 word reads/writes).
module dram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  output logic              rlast0,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [3:0]        req1_wstrb,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic              done1,
  output logic [3:0]        ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [3:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [3:0]        RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [3:0]        AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [3:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [3:0]        BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_gnt;
  logic              r_gnt;
  logic              r_we;
  logic              r_hold;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic [3:0]        r_beats;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_last_beat;
  logic              w_unused;

  assign w_unused = ^{RID, RRESP, BID, BRESP, r_addr[1:0]};

  // r_hold blocks a grant in the first IDLE cycle after R/B
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n && r_state == S_IDLE && !r_hold) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = r_last_gnt;
        w_gnt1 = !r_last_gnt;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  assign ARID    = r_gnt ? 4'd1 : 4'd0;
  assign ARLEN   = r_gnt ? 4'd0 : 4'd3;
  assign ARBURST = r_gnt ? 2'b00 : 2'b01;
  assign ARSIZE  = 3'b010;
  assign ARADDR  = r_gnt ? {r_addr[ADDR_W-1:2], 2'b00}
                         : {r_addr[ADDR_W-1:4], 4'b0000};

  assign AWID    = 4'd1;
  assign AWLEN   = 4'd0;
  assign AWBURST = 2'b00;
  assign AWSIZE  = 3'b010;
  assign AWADDR  = {r_addr[ADDR_W-1:2], 2'b00};
  assign WDATA   = r_wdata;
  assign WSTRB   = r_wstrb;

  assign w_last_beat = RLAST || (r_beats == ARLEN);

  always_comb begin
    w_next  = r_state;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    WLAST   = 1'b0;
    BREADY  = 1'b0;
    rdata0  = '0;
    rvalid0 = 1'b0;
    rlast0  = 1'b0;
    rdata1  = '0;
    rvalid1 = 1'b0;
    done1   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt0)
          w_next = S_AR;
        else if (w_gnt1)
          w_next = req1_we ? S_AW : S_AR;
      end
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) w_next = S_R;
      end
      S_R: begin
        RREADY = 1'b1;
        if (RVALID) begin
          if (r_gnt) begin
            rdata1  = RDATA;
            rvalid1 = 1'b1;
            done1   = 1'b1;
          end else begin
            rdata0  = RDATA;
            rvalid0 = 1'b1;
            rlast0  = w_last_beat;
          end
          if (w_last_beat) w_next = S_IDLE;
        end
      end
      S_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) w_next = S_W;
      end
      S_W: begin
        WVALID = 1'b1;
        WLAST  = 1'b1;
        if (WREADY) w_next = S_B;
      end
      S_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          done1  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_gnt      <= 1'b0;
      r_we       <= 1'b0;
      r_hold     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_beats    <= '0;
    end else begin
      r_state <= w_next;
      r_hold  <= (r_state == S_R || r_state == S_B)
              && (w_next == S_IDLE);
      if (w_gnt0 || w_gnt1) begin
        r_gnt      <= w_gnt1;
        r_last_gnt <= w_gnt1;
        r_we       <= w_gnt1 && req1_we;
        r_addr     <= w_gnt1 ? req1_addr : req0_addr;
        r_wdata    <= w_gnt1 ? req1_wdata : '0;
        r_wstrb    <= w_gnt1 ? req1_wstrb : 4'b0000;
        r_beats    <= '0;
      end else if (r_state == S_R && RVALID) begin
        r_beats <= r_beats + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: arbitration table plus
// write, stalled-AR and mid-burst reset sequences.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_addr;
  logic [31:0] rdata0;
  logic        rvalid0, rlast0;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic [3:0]  req1_wstrb;
  logic [31:0] rdata1;
  logic        rvalid1, done1;
  logic [3:0]  ARID, ARLEN;
  logic [31:0] ARADDR;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic [3:0]  AWID, AWLEN;
  logic [31:0] AWADDR;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  always #5 clk = ~clk;

  dram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .rdata0(rdata0),
    .rvalid0(rvalid0), .rlast0(rlast0),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .rdata1(rdata1), .rvalid1(rvalid1), .done1(done1),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY)
  );

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic        v1;
    logic [31:0] a1;
    int          gnt;
    logic [31:0] araddr;
    int          arw;
  } vec_t;

  vec_t tbl [7];
  int   total = 0;
  int   bad   = 0;
  int   last_g;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic g0, g1;
    #1;
    g0 = req0_valid && req0_ready;
    g1 = req1_valid && req1_ready;
    chk("ready_onehot", {63'd0, req0_ready & req1_ready}, 0);
    @(posedge clk);
    #1;
    if (g0) begin req0_valid = 1'b0; last_g = 0; end
    if (g1) begin req1_valid = 1'b0; last_g = 1; end
  endtask

  task automatic serve_read(input int id, input logic [31:0] addr,
                            input int arw, input int tag);
    int          n;
    int          beats;
    logic [31:0] d;
    n = 0;
    beats = (id == 0) ? 4 : 1;
    while (!ARVALID && n < 20) begin tick(); n++; end
    chk("ar_timeout", {63'd0, ARVALID}, 1);
    if (!ARVALID) return;
    chk("grant_id", 64'(last_g), 64'(id));
    chk("ARID", ARID, 64'(id));
    chk("ARADDR", ARADDR, addr);
    chk("ARLEN", ARLEN, (id == 0) ? 3 : 0);
    chk("ARBURST", ARBURST, (id == 0) ? 1 : 0);
    chk("ARSIZE", ARSIZE, 2);
    repeat (arw) begin
      tick();
      chk("arvalid_hold", {63'd0, ARVALID}, 1);
      chk("araddr_hold", ARADDR, addr);
      chk("ready_held_off", {62'd0, req0_ready, req1_ready}, 0);
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    #1;
    chk("arvalid_drop", {63'd0, ARVALID}, 0);
    chk("rready", {63'd0, RREADY}, 1);
    for (int b = 0; b < beats; b++) begin
      d = 32'hC0DE_0000 + 32'(tag * 16 + b);
      RDATA  = d;
      RVALID = 1'b1;
      RLAST  = (b == beats - 1);
      RID    = (b == 1) ? 4'h7 : 4'(id);
      #1;
      if (id == 0) begin
        chk("rvalid0", {63'd0, rvalid0}, 1);
        chk("rdata0", rdata0, d);
        chk("rlast0", {63'd0, rlast0}, (b == beats - 1) ? 1 : 0);
        chk("rvalid1_off", {63'd0, rvalid1}, 0);
      end else begin
        chk("rvalid1", {63'd0, rvalid1}, 1);
        chk("rdata1", rdata1, d);
        chk("done1_read", {63'd0, done1}, 1);
        chk("rvalid0_off", {63'd0, rvalid0}, 0);
      end
      tick();
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    #1;
    chk("no_grant_on_return", {62'd0, req0_ready, req1_ready}, 0);
    chk("rready_off", {63'd0, RREADY}, 0);
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0204, 0, 32'h0000_0100, 0};
    tbl[1] = '{1'b1, 32'h0000_0140, 1'b0, 32'h0,         1, 32'h0000_0204, 0};
    tbl[2] = '{1'b0, 32'h0,         1'b0, 32'h0,         0, 32'h0000_0140, 0};
    tbl[3] = '{1'b1, 32'h0000_1234, 1'b0, 32'h0,         0, 32'h0000_1230, 0};
    tbl[4] = '{1'b0, 32'h0,         1'b1, 32'h0000_5007, 1, 32'h0000_5004, 0};
    tbl[5] = '{1'b1, 32'hABCD_EF0F, 1'b1, 32'h0000_0010, 0, 32'hABCD_EF00, 5};
    tbl[6] = '{1'b0, 32'h0,         1'b0, 32'h0,         1, 32'h0000_0010, 0};

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = '0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = '0;
    req1_wdata = '0;   req1_wstrb = '0;
    ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0;
    RLAST = 1'b0; RVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    BID = '0; BRESP = '0; BVALID = 1'b0;
    last_g = -1;
    #2;
    chk("rst_req0_ready", {63'd0, req0_ready}, 0);
    chk("rst_req1_ready", {63'd0, req1_ready}, 0);
    chk("rst_valids", {60'd0, ARVALID, AWVALID, WVALID, RREADY}, 0);
    chk("rst_bready", {63'd0, BREADY}, 0);
    chk("rst_rets", {60'd0, rvalid0, rvalid1, rlast0, done1}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].v0) begin req0_valid = 1'b1; req0_addr = tbl[i].a0; end
      if (tbl[i].v1) begin req1_valid = 1'b1; req1_addr = tbl[i].a1; end
      last_g = -1;
      serve_read(tbl[i].gnt, tbl[i].araddr, tbl[i].arw, i);
    end

    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h0000_2008;
    req1_wdata = 32'hDEAD_BEEF; req1_wstrb = 4'b0011;
    last_g = -1;
    n = 0;
    while (!AWVALID && n < 20) begin tick(); n++; end
    chk("aw_timeout", {63'd0, AWVALID}, 1);
    chk("grant_w", 64'(last_g), 1);
    chk("AWADDR", AWADDR, 32'h0000_2008);
    chk("AWLEN", AWLEN, 0);
    chk("AWBURST", AWBURST, 0);
    chk("AWSIZE", AWSIZE, 2);
    chk("AWID", AWID, 1);
    chk("arvalid_in_aw", {63'd0, ARVALID}, 0);
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    req1_we = 1'b0;
    #1;
    chk("awvalid_drop", {63'd0, AWVALID}, 0);
    chk("wvalid", {63'd0, WVALID}, 1);
    chk("wlast", {63'd0, WLAST}, 1);
    chk("WDATA", WDATA, 32'hDEAD_BEEF);
    chk("WSTRB", WSTRB, 4'b0011);
    chk("done1_early", {63'd0, done1}, 0);
    tick();
    chk("wvalid_hold", {63'd0, WVALID}, 1);
    WREADY = 1'b1;
    tick();
    WREADY = 1'b0;
    #1;
    chk("wvalid_drop", {63'd0, WVALID}, 0);
    chk("bready", {63'd0, BREADY}, 1);
    chk("done1_before_b", {63'd0, done1}, 0);
    BVALID = 1'b1; BID = 4'h5;
    #1;
    chk("done1_on_b", {63'd0, done1}, 1);
    tick();
    BVALID = 1'b0;
    #1;
    chk("done1_one_cycle", {63'd0, done1}, 0);
    chk("bready_off", {63'd0, BREADY}, 0);

    req0_valid = 1'b1; req0_addr = 32'h0000_0300;
    n = 0;
    while (!ARVALID && n < 20) begin tick(); n++; end
    chk("ar2_timeout", {63'd0, ARVALID}, 1);
    chk("ARADDR_r2", ARADDR, 32'h0000_0300);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    RVALID = 1'b1; RDATA = 32'h1111_0001; RLAST = 1'b0;
    tick();
    RDATA = 32'h1111_0002;
    req1_valid = 1'b1; req1_addr = 32'h0000_0044;
    #1;
    chk("beat2_seen", {63'd0, rvalid0}, 1);
    rst_n = 1'b0;
    #1;
    chk("rrst_rvalid0", {63'd0, rvalid0}, 0);
    chk("rrst_rdata0", rdata0, 0);
    chk("rrst_rlast0", {63'd0, rlast0}, 0);
    chk("rrst_rready", {63'd0, RREADY}, 0);
    chk("rrst_valids", {61'd0, ARVALID, AWVALID, WVALID}, 0);
    chk("rrst_readys", {62'd0, req0_ready, req1_ready}, 0);
    chk("rrst_done1", {63'd0, done1}, 0);
    RVALID = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    last_g = -1;
    serve_read(1, 32'h0000_0044, 0, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all requester and AXI address ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all requester and AXI data ports.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid/req0_ready  input/output  1/1  requester 0 (instruction side) read request handshake.
REQ-006 req0_addr  input  ADDR_W  requester 0 line address; bits [3:0] ignored, forced 0 on ARADDR.
REQ-007 rdata0/rvalid0/rlast0  output  DATA_W/1/1  requester 0 return beat, valid, final beat.
REQ-008 req1_valid/req1_ready/req1_we  input/output/input  1/1/1  requester 1 (data side) handshake; we=1 write, 0 read.
REQ-009 req1_addr/req1_wdata/req1_wstrb  input  ADDR_W/DATA_W/4  requester 1 word address, write data, byte strobes (active high).
REQ-010 rdata1/rvalid1/done1  output  DATA_W/1/1  requester 1 read data, read-data valid, completion pulse (read or write).
REQ-011 ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID, ARREADY  output 4/ADDR_W/4/3/2/1, input 1  AXI read address channel to DRAM slave.
REQ-012 RID/RDATA/RRESP/RLAST/RVALID input 4/DATA_W/2/1/1, RREADY output 1  AXI read data channel.
REQ-013 AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID, AWREADY  output 4/ADDR_W/4/3/2/1, input 1  AXI write address channel.
REQ-014 WDATA/WSTRB/WLAST/WVALID output DATA_W/4/1/1, WREADY input 1  AXI write data channel.
REQ-015 BID/BRESP/BVALID input 4/2/1, BREADY output 1  AXI write response channel.

Function
REQ-016 SHALL implement FSM states IDLE, AR, R, AW, W, B; exactly one AXI transaction outstanding at any time.
REQ-017 IDLE: req0_ready/req1_ready SHALL be combinational grants; at most one high per cycle, only in IDLE.
REQ-018 Arbitration SHALL be round-robin via 1-bit last_grant: both valid -> grant the requester not granted last; single valid -> grant it.
REQ-019 On grant handshake SHALL capture addr, we, wdata, wstrb, update last_grant, go to AR (read) or AW (write) next cycle.
REQ-020 Requester 0 read SHALL issue ARLEN=3, ARBURST=INCR(2'b01), ARSIZE=3'b010, ARID=0, ARADDR={addr[ADDR_W-1:4],4'b0}.
REQ-021 Requester 1 read SHALL issue ARLEN=0, ARBURST=FIXED(2'b00), ARSIZE=3'b010, ARID=1, ARADDR={addr[ADDR_W-1:2],2'b0}.
REQ-022 Requester 1 write SHALL issue AWLEN=0, AWBURST=FIXED, AWSIZE=3'b010, AWID=1, AWADDR word-aligned.
REQ-023 AR/AW: ARVALID/AWVALID high until ARREADY/AWREADY sampled high, then drop; next state R/W.
REQ-024 ARADDR/AWADDR, ARLEN, ARBURST SHALL stay stable from AR/AW entry until return to IDLE (slave decodes them combinationally throughout).
REQ-025 R: RREADY=1; each RVALID beat SHALL route RDATA combinationally to the granted requester's rdata/rvalid, other rvalid 0.
REQ-026 R exit: RVALID&&RLAST, or beat counter reaching ARLEN+1 beats; rlast0 marks requester 0 final beat; done1 pulses with requester 1 beat; next IDLE.
REQ-027 W: WVALID=1, WLAST=1, WDATA/WSTRB from capture until WREADY sampled high; next B.
REQ-028 B: BREADY=1; on BVALID SHALL pulse done1 one cycle and go IDLE; BRESP not checked.
REQ-029 New grant SHALL NOT occur in the cycle the FSM returns to IDLE from R/B; earliest next grant is one cycle after.
REQ-030 Requests arriving outside IDLE SHALL be held off (ready=0); requesters must hold valid and payload.
REQ-031 RID/BID mismatch with granted ID SHALL be ignored (single outstanding guarantees order).

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, last_grant=1 (requester 0 wins first tie), all VALID/READY outputs, rvalid*, rlast0, done1, req*_ready low, captured registers and beat counter 0.
REQ-033 Reset mid-transaction SHALL abandon it without completing pending beats or pulses.

Verification
REQ-034 req0 at 0x0000_1234 alone -> ARADDR=0x0000_1230, ARLEN=3, ARBURST=1; 4 beats on rdata0, rlast0 on 4th only.
REQ-035 req0 and req1 read both valid from reset -> req0 served first, then req1 (ARLEN=0, ARID=1); repeat tie -> req1 first.
REQ-036 req1 write 0x0000_2008, wdata 0xDEADBEEF, wstrb 4'b0011 -> AW then W with WSTRB=4'b0011, WLAST=1; done1 one cycle on BVALID.
REQ-037 ARREADY held low 5 cycles -> ARVALID/ARADDR stable all 5 cycles; no req*_ready during.
REQ-038 rst_n low during R beat 2 -> all outputs 0 same cycle; after release, new req1 read completes normally.
